branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Consumes the blt/bne flags from the execute-stage branch comparator and the decoded EX-stage
//  control flags. Decides taken/not-taken and computes the target PC. Drives a registered PC
//  redirect to fetch with a valid/ready handshake, then flushes the wrong-path IF/ID and ID/EX
//  contents. Sits between the EX-stage comparator and the fetch/pipeline-register control logic.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles flush_if_id/flush_id_ex stay high after the redirect is accepted (0..15)
//  CNT_W         16  width of the resolved/taken performance counters
// PORTS
//  clock          in   1      rising-edge clock
//  reset_n        in   1      asynchronous active-low reset
//  ex_valid       in   1      EX-stage instruction is valid this cycle
//  ex_is_bne      in   1      EX instruction is bne
//  ex_is_blt      in   1      EX instruction is blt
//  ex_is_j        in   1      EX instruction is j/jal
//  ex_is_jr       in   1      EX instruction is jr
//  ex_pc          in   32     PC of the EX instruction (word address)
//  ex_imm         in   17     branch immediate, two's complement
//  ex_jtarget     in   27     jump target field
//  ex_jr_val      in   32     register value for jr
//  blt            in   1      comparator: A < B (signed)
//  bne            in   1      comparator: A != B
//  fetch_ready    in   1      fetch accepts redirect this cycle
//  redirect_valid out  1      redirect request to fetch
//  redirect_pc    out  32     new fetch PC
//  flush_if_id    out  1      squash IF/ID register
//  flush_id_ex    out  1      squash ID/EX register
//  stall_pipe     out  1      freeze PC and IF/ID/EX pipeline registers
//  resolved_cnt   out  CNT_W  count of control-flow instructions resolved
//  taken_cnt      out  CNT_W  count of redirects issued
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE. All outputs 0, including redirect_pc and both
//    counters. Reset mid-REDIRECT/FLUSH aborts immediately; no redirect is left pending.
//  - Decode priority when more than one flag is set: jr > j > bne > blt. ex_valid=0 ignores all
//    flags.
//  - taken = ex_valid & (ex_is_jr | ex_is_j | (ex_is_bne & bne) | (ex_is_blt & blt)).
//  - Target selection:
//    - bne/blt: ex_pc + 1 + sext32(ex_imm), mod 2^32; wrap-around is allowed.
//    - j: {ex_pc[31:27], ex_jtarget}.
//    - jr: ex_jr_val.
//  - FSM states: IDLE, REDIRECT, FLUSH. All outputs are registered.
//    - IDLE: ex inputs are sampled every edge.
//      - Taken: load redirect_pc, set redirect_valid, flush_if_id, flush_id_ex and stall_pipe;
//        go to REDIRECT. Latency: ex_valid at edge N -> redirect_valid high after edge N.
//      - Not taken with a branch/jump flag set: count only; stay in IDLE.
//    - REDIRECT: hold redirect_valid, redirect_pc, flushes and stall stable until
//      fetch_ready=1 at an edge.
//      - FLUSH_CYCLES>0: drop redirect_valid, load the flush counter with FLUSH_CYCLES, go to FLUSH.
//      - FLUSH_CYCLES=0: clear all outputs, go to IDLE.
//    - FLUSH: flushes and stall_pipe stay high. Decrement the counter each edge; at 1 -> clear,
//      go to IDLE.
//    - ex_* inputs are ignored outside IDLE; the pipeline is stalled, so EX cannot present a new
//      branch.
//  - stall_pipe = (state != IDLE), registered.
//  - Counters: resolved_cnt increments on every IDLE edge where ex_valid and any flag is set.
//    taken_cnt increments with each taken entry to REDIRECT. Both wrap modulo 2^CNT_W.
//  - fetch_ready while not in REDIRECT has no effect.
// TESTING
//  1. Reset: reset_n=0 mid-REDIRECT, async, no clock edge -> all outputs 0 immediately;
//     release -> IDLE, counters 0.
//  2. bne taken: ex_pc=0x100, ex_imm=-4, bne=1, fetch_ready=1 -> redirect_pc=0xFD one cycle later;
//     flushes high 1+2 cycles; stall_pipe low after 3rd cycle.
//  3. blt not taken: blt=0 -> no redirect; resolved_cnt+1, taken_cnt unchanged.
//  4. Handshake hold: jr with ex_jr_val=0xDEAD_BEEF and fetch_ready=0 for 5 cycles ->
//     redirect_valid/pc held stable; accepted on 6th cycle.
//  5. Priority/wrap: ex_is_j=ex_is_bne=1, ex_pc=0xF800_0000, ex_jtarget=0x7FF_FFFF ->
//     redirect_pc=0xFFFF_FFFF (jump wins).
//     Separately: ex_pc=0xFFFF_FFFF, ex_imm=0 -> branch target 0x0.
//  6. Counter wrap: CNT_W=4, 16 taken branches -> taken_cnt returns to 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: decides taken/not-taken for EX-stage control flow,
// issues a registered PC redirect to fetch and squashes the wrong path.
//
// Ports:
//   clock, reset_n                   clock / async active-low reset
//   ex_valid, ex_is_{bne,blt,j,jr}   decoded EX control flags
//   ex_pc, ex_imm, ex_jtarget        target operands
//   ex_jr_val                        register target for jr
//   blt, bne                         comparator results
//   fetch_ready                      fetch accepts the redirect
//   redirect_valid, redirect_pc      redirect request to fetch
//   flush_if_id, flush_id_ex         wrong-path squash
//   stall_pipe                       freeze PC and pipeline registers
//   resolved_cnt, taken_cnt          performance counters
module branch_resolve_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ex_valid,
  input  logic             ex_is_bne,
  input  logic             ex_is_blt,
  input  logic             ex_is_j,
  input  logic             ex_is_jr,
  input  logic [31:0]      ex_pc,
  input  logic [16:0]      ex_imm,
  input  logic [26:0]      ex_jtarget,
  input  logic [31:0]      ex_jr_val,
  input  logic             blt,
  input  logic             bne,
  input  logic             fetch_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             stall_pipe,
  output logic [CNT_W-1:0] resolved_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDIRECT,
    S_FLUSH
  } state_e;

  localparam logic [3:0] FC = 4'(FLUSH_CYCLES);

  state_e             state_q, state_d;
  logic               vld_q, vld_d;
  logic [31:0]        pc_q, pc_d;
  logic               flush_q, flush_d;
  logic               stall_q, stall_d;
  logic [3:0]         fcnt_q, fcnt_d;
  logic [CNT_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   tkn_q, tkn_d;

  logic        resolve;
  logic        taken;
  logic [31:0] br_tgt;
  logic [31:0] target;

  assign resolve = ex_valid &
    (ex_is_jr | ex_is_j | ex_is_bne | ex_is_blt);
  assign taken = ex_valid &
    (ex_is_jr | ex_is_j |
     (ex_is_bne & bne) | (ex_is_blt & blt));

  // Branch offset is relative to the next word; wraps mod 2^32.
  assign br_tgt = ex_pc + 32'd1 +
    {{15{ex_imm[16]}}, ex_imm};

  // Overlapping flags are legal, so a priority chain (jr > j > branch).
  always_comb begin
    if (ex_is_jr)
      target = ex_jr_val;
    else if (ex_is_j)
      target = {ex_pc[31:27], ex_jtarget};
    else
      target = br_tgt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (taken)
          state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (fetch_ready)
          state_d = (FLUSH_CYCLES > 0) ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        if (fcnt_q <= 4'd1)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    fcnt_d  = fcnt_q;
    res_d   = res_q;
    tkn_d   = tkn_q;
    vld_d   = (state_d == S_REDIRECT);
    flush_d = (state_d != S_IDLE);
    stall_d = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (resolve)
          res_d = res_q + CNT_W'(1);
        if (taken) begin
          pc_d  = target;
          tkn_d = tkn_q + CNT_W'(1);
        end
      end
      S_REDIRECT: begin
        if (fetch_ready)
          fcnt_d = FC;
      end
      S_FLUSH: begin
        fcnt_d = fcnt_q - 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q   <= 1'b0;
      pc_q    <= '0;
      flush_q <= 1'b0;
      stall_q <= 1'b0;
      fcnt_q  <= '0;
      res_q   <= '0;
      tkn_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      stall_q <= stall_d;
      fcnt_q  <= fcnt_d;
      res_q   <= res_d;
      tkn_q   <= tkn_d;
    end
  end

  assign redirect_valid = vld_q;
  assign redirect_pc    = pc_q;
  assign flush_if_id    = flush_q;
  assign flush_id_ex    = flush_q;
  assign stall_pipe     = stall_q;
  assign resolved_cnt   = res_q;
  assign taken_cnt      = tkn_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: default instance plus a
// 4-bit-counter instance sharing the same stimulus.
module tb_branch_resolve_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        ex_valid = 0, ex_is_bne = 0, ex_is_blt = 0;
  logic        ex_is_j = 0, ex_is_jr = 0;
  logic [31:0] ex_pc = '0;
  logic [16:0] ex_imm = '0;
  logic [26:0] ex_jtarget = '0;
  logic [31:0] ex_jr_val = '0;
  logic        blt = 0, bne = 0, fetch_ready = 0;

  logic        redirect_valid, flush_if_id, flush_id_ex, stall_pipe;
  logic [31:0] redirect_pc;
  logic [15:0] resolved_cnt, taken_cnt;

  logic        s_valid, s_fif, s_fex, s_stall;
  logic [31:0] s_pc;
  logic [3:0]  s_res, s_tkn;

  int tests = 0;
  int fails = 0;
  int exp_res = 0;
  int exp_tkn = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_pc;

  always #5 clock = ~clock;

  branch_resolve_unit dut (
    .clock(clock), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_is_bne(ex_is_bne),
    .ex_is_blt(ex_is_blt), .ex_is_j(ex_is_j),
    .ex_is_jr(ex_is_jr), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_jtarget(ex_jtarget),
    .ex_jr_val(ex_jr_val), .blt(blt), .bne(bne),
    .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_pipe(stall_pipe),
    .resolved_cnt(resolved_cnt), .taken_cnt(taken_cnt)
  );

  branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
    .clock(clock), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_is_bne(ex_is_bne),
    .ex_is_blt(ex_is_blt), .ex_is_j(ex_is_j),
    .ex_is_jr(ex_is_jr), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_jtarget(ex_jtarget),
    .ex_jr_val(ex_jr_val), .blt(blt), .bne(bne),
    .fetch_ready(fetch_ready),
    .redirect_valid(s_valid), .redirect_pc(s_pc),
    .flush_if_id(s_fif), .flush_id_ex(s_fex),
    .stall_pipe(s_stall),
    .resolved_cnt(s_res), .taken_cnt(s_tkn)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one EX instruction for one edge; expected target goes to sb.
  task automatic issue(
    input logic v, input logic jr, input logic j,
    input logic bn, input logic bl,
    input logic [31:0] pc, input logic [16:0] imm,
    input logic [26:0] jt, input logic [31:0] jrv,
    input logic c_blt, input logic c_bne
  );
    logic tk;
    ex_valid = v; ex_is_jr = jr; ex_is_j = j;
    ex_is_bne = bn; ex_is_blt = bl;
    ex_pc = pc; ex_imm = imm; ex_jtarget = jt;
    ex_jr_val = jrv; blt = c_blt; bne = c_bne;
    tk = v & (jr | j | (bn & c_bne) | (bl & c_blt));
    if (v & (jr | j | bn | bl)) exp_res++;
    if (tk) begin
      exp_tkn++;
      if (jr) sb.push_back(jrv);
      else if (j) sb.push_back({pc[31:27], jt});
      else sb.push_back(pc + 32'd1 + 32'($signed(imm)));
    end
    tick();
    ex_valid = 0; ex_is_jr = 0; ex_is_j = 0;
    ex_is_bne = 0; ex_is_blt = 0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    fetch_ready = 1;
    while ((stall_pipe !== 1'b0 || s_stall !== 1'b0) && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (stall_pipe !== 1'b0 || s_stall !== 1'b0) begin
      fails++;
      $display("FAIL %s_drain stall=%0b/%0b exp 0 (timeout)",
               nm, stall_pipe, s_stall);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #12;
    tests++;
    if ({redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
         stall_pipe, resolved_cnt, taken_cnt, s_res, s_tkn} !== '0) begin
      fails++;
      $display("FAIL reset_init v=%0b pc=%h st=%0b res=%0d tkn=%0d exp 0",
               redirect_valid, redirect_pc, stall_pipe,
               resolved_cnt, taken_cnt);
    end
    #2 reset_n = 1'b1;
    fetch_ready = 0;
    tick();
    issue(1, 1, 0, 0, 0, 32'h0, 17'h0, 27'h0, 32'h1234_5678, 0, 0);
    exp_pc = sb.pop_front();
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc) begin
      fails++;
      $display("FAIL reset_pre v=%0b pc=%h exp 1 %h",
               redirect_valid, redirect_pc, exp_pc);
    end
    #3 reset_n = 1'b0;
    #1;
    tests++;
    if ({redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
         stall_pipe, resolved_cnt, taken_cnt, s_valid, s_stall,
         s_res, s_tkn} !== '0) begin
      fails++;
      $display("FAIL reset_async v=%0b pc=%h st=%0b res=%0d tkn=%0d exp 0",
               redirect_valid, redirect_pc, stall_pipe,
               resolved_cnt, taken_cnt);
    end
    #2 reset_n = 1'b1;
    exp_res = 0; exp_tkn = 0;
    sb.delete();
    fetch_ready = 1;
    tick(); tick();
    tests++;
    if ({redirect_valid, stall_pipe, resolved_cnt, taken_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_release v=%0b st=%0b res=%0d tkn=%0d exp 0",
               redirect_valid, stall_pipe, resolved_cnt, taken_cnt);
    end
  endtask

  task automatic test_bne_taken();
    logic [3:0] e;
    fetch_ready = 1;
    issue(1, 0, 0, 1, 0, 32'h100, 17'h1FFFC, 27'h0, 32'h0, 0, 1);
    exp_pc = sb.pop_front();
    tests++;
    if (redirect_pc !== exp_pc) begin
      fails++;
      $display("FAIL bne_pc got %h exp %h", redirect_pc, exp_pc);
    end
    for (int i = 0; i < 4; i++) begin
      e = (i == 0) ? 4'b1111 : (i < 3) ? 4'b0111 : 4'b0000;
      tests++;
      if ({redirect_valid, flush_if_id, flush_id_ex, stall_pipe} !== e) begin
        fails++;
        $display("FAIL bne_seq%0d got %b exp %b", i,
                 {redirect_valid, flush_if_id, flush_id_ex, stall_pipe}, e);
      end
      tick();
    end
    tests++;
    if (resolved_cnt !== 16'(exp_res) || taken_cnt !== 16'(exp_tkn)) begin
      fails++;
      $display("FAIL bne_cnt got %0d/%0d exp %0d/%0d",
               resolved_cnt, taken_cnt, exp_res, exp_tkn);
    end
  endtask

  task automatic test_not_taken();
    issue(1, 0, 0, 0, 1, 32'h40, 17'h10, 27'h0, 32'h0, 0, 1);
    issue(1, 0, 0, 1, 0, 32'h44, 17'h10, 27'h0, 32'h0, 1, 0);
    issue(0, 0, 1, 1, 1, 32'h48, 17'h10, 27'h5, 32'h0, 1, 1);
    tests++;
    if (redirect_valid !== 1'b0 || stall_pipe !== 1'b0) begin
      fails++;
      $display("FAIL nt_idle v=%0b st=%0b exp 0 0",
               redirect_valid, stall_pipe);
    end
    tests++;
    if (resolved_cnt !== 16'(exp_res) || taken_cnt !== 16'(exp_tkn)) begin
      fails++;
      $display("FAIL nt_cnt got %0d/%0d exp %0d/%0d",
               resolved_cnt, taken_cnt, exp_res, exp_tkn);
    end
  endtask

  task automatic test_hold();
    fetch_ready = 0;
    issue(1, 1, 0, 0, 0, 32'h200, 17'h0, 27'h0, 32'hDEAD_BEEF, 0, 0);
    exp_pc = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc ||
          stall_pipe !== 1'b1 || flush_if_id !== 1'b1) begin
        fails++;
        $display("FAIL hold%0d v=%0b pc=%h st=%0b exp 1 %h 1",
                 i, redirect_valid, redirect_pc, stall_pipe, exp_pc);
      end
      // A new branch presented while stalled must be ignored.
      ex_valid = (i == 2); ex_is_j = (i == 2);
      tick();
      ex_valid = 0; ex_is_j = 0;
    end
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc) begin
      fails++;
      $display("FAIL hold_end v=%0b pc=%h exp 1 %h",
               redirect_valid, redirect_pc, exp_pc);
    end
    fetch_ready = 1;
    tick();
    tests++;
    if (redirect_valid !== 1'b0 || stall_pipe !== 1'b1) begin
      fails++;
      $display("FAIL hold_accept v=%0b st=%0b exp 0 1",
               redirect_valid, stall_pipe);
    end
    drain("hold");
    tests++;
    if (resolved_cnt !== 16'(exp_res) || taken_cnt !== 16'(exp_tkn)) begin
      fails++;
      $display("FAIL hold_cnt got %0d/%0d exp %0d/%0d",
               resolved_cnt, taken_cnt, exp_res, exp_tkn);
    end
  endtask

  task automatic test_priority_wrap();
    fetch_ready = 1;
    issue(1, 0, 1, 1, 0, 32'hF800_0000, 17'h5, 27'h7FF_FFFF, 32'h0, 0, 1);
    exp_pc = sb.pop_front();
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc) begin
      fails++;
      $display("FAIL prio_j v=%0b pc=%h exp 1 %h",
               redirect_valid, redirect_pc, exp_pc);
    end
    drain("prio_j");
    issue(1, 1, 1, 1, 1, 32'h300, 17'h8, 27'h55, 32'hCAFE_0001, 1, 1);
    exp_pc = sb.pop_front();
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc) begin
      fails++;
      $display("FAIL prio_jr v=%0b pc=%h exp 1 %h",
               redirect_valid, redirect_pc, exp_pc);
    end
    drain("prio_jr");
    issue(1, 0, 0, 1, 0, 32'hFFFF_FFFF, 17'h0, 27'h0, 32'h0, 0, 1);
    exp_pc = sb.pop_front();
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc) begin
      fails++;
      $display("FAIL wrap_br v=%0b pc=%h exp 1 %h",
               redirect_valid, redirect_pc, exp_pc);
    end
    drain("wrap_br");
  endtask

  task automatic test_back_to_back_wrap();
    logic [3:0] start4;
    logic [31:0] pc;
    logic [16:0] imm;
    start4 = 4'(exp_tkn);
    fetch_ready = 1;
    for (int i = 0; i < 16; i++) begin
      pc  = $urandom;
      imm = 17'($urandom);
      issue(1, 0, 0, 0, 1, pc, imm, 27'h0, 32'h0, 1, 0);
      exp_pc = sb.pop_front();
      tests++;
      if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc ||
          s_pc !== exp_pc) begin
        fails++;
        $display("FAIL b2b%0d v=%0b pc=%h/%h exp 1 %h",
                 i, redirect_valid, redirect_pc, s_pc, exp_pc);
      end
      drain("b2b");
    end
    tests++;
    if (taken_cnt !== 16'(exp_tkn) || s_tkn !== start4) begin
      fails++;
      $display("FAIL cnt_wrap tkn=%0d tkn4=%0d exp %0d %0d",
               taken_cnt, s_tkn, exp_tkn, start4);
    end
    tests++;
    if (resolved_cnt !== 16'(exp_res) || s_res !== 4'(exp_res)) begin
      fails++;
      $display("FAIL res_wrap res=%0d res4=%0d exp %0d %0d",
               resolved_cnt, s_res, exp_res, 4'(exp_res));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bne_taken();
    test_not_taken();
    test_hold();
    test_priority_wrap();
    test_back_to_back_wrap();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_empty left=%0d exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
